// File: rtl/nano_ctrl_pkg.sv
// Shared constants and types for the nano program sequencer.
// Opcode prefixes, register codes, bus selects and enable indices.
package nano_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_HALT
  } state_t;

  localparam logic       PFX_LD  = 1'b0;
  localparam logic [1:0] PFX_MV  = 2'b10;
  localparam logic [2:0] PFX_ALU = 3'b110;
  localparam logic [3:0] PFX_JMP = 4'b1110;

  localparam logic [3:0] JC_JMP = 4'd0;
  localparam logic [3:0] JC_JZ  = 4'd1;
  localparam logic [3:0] JC_JNZ = 4'd2;

  localparam logic [7:0] INSN_NOP  = 8'hF0;
  localparam logic [7:0] INSN_HALT = 8'hFF;

  localparam logic [2:0] CODE_X0 = 3'd0;
  localparam logic [2:0] CODE_X1 = 3'd1;
  localparam logic [2:0] CODE_Y0 = 3'd2;
  localparam logic [2:0] CODE_Y1 = 3'd3;
  localparam logic [2:0] CODE_O  = 3'd4;
  localparam logic [2:0] CODE_R  = 3'd4;
  localparam logic [2:0] CODE_M  = 3'd5;
  localparam logic [2:0] CODE_I  = 3'd6;
  localparam logic [2:0] CODE_DM = 3'd7;

  localparam logic [3:0] SEL_IMM   = 4'd8;
  localparam logic [3:0] SEL_IPINS = 4'd9;
  localparam logic [3:0] SEL_ZERO  = 4'd10;

  localparam int REN_X0 = 0;
  localparam int REN_X1 = 1;
  localparam int REN_Y0 = 2;
  localparam int REN_Y1 = 3;
  localparam int REN_R  = 4;
  localparam int REN_M  = 5;
  localparam int REN_I  = 6;
  localparam int REN_DM = 7;
  localparam int REN_O  = 8;

  // Destination code to one-hot register enable.
  function automatic logic [8:0] dst_en(
    input logic [2:0] ddd
  );
    logic [8:0] en;
    en = '0;
    unique case (ddd)
      CODE_X0: en[REN_X0] = 1'b1;
      CODE_X1: en[REN_X1] = 1'b1;
      CODE_Y0: en[REN_Y0] = 1'b1;
      CODE_Y1: en[REN_Y1] = 1'b1;
      CODE_O:  en[REN_O]  = 1'b1;
      CODE_M:  en[REN_M]  = 1'b1;
      CODE_I:  en[REN_I]  = 1'b1;
      CODE_DM: en[REN_DM] = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/nano_decoder.sv
// Combinational instruction decoder.
// Maps the instruction register to unit controls.
module nano_decoder
  import nano_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       is_jump,
  output logic [3:0] jump_cond,
  output logic       is_halt
);

  logic [2:0] mv_dst;
  logic [2:0] mv_src;
  logic       dm_use;

  assign mv_dst    = ir[5:3];
  assign mv_src    = ir[2:0];
  assign jump_cond = ir[3:0];

  always_comb begin
    reg_en     = '0;
    source_sel = SEL_ZERO;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    dm_use     = 1'b0;
    unique case (1'b1)
      ir[7] == PFX_LD: begin
        reg_en     = dst_en(ir[6:4]);
        source_sel = SEL_IMM;
      end
      ir[7:6] == PFX_MV: begin
        reg_en = dst_en(mv_dst);
        if (mv_src == mv_dst)
          source_sel = SEL_IPINS;
        else
          source_sel = {1'b0, mv_src};
        // i_pins substitution hides a dm source
        dm_use = (mv_dst == CODE_DM) ||
                 (source_sel == {1'b0, CODE_DM});
        if (dm_use) begin
          reg_en[REN_I] = 1'b1;
          i_sel = (mv_dst != CODE_I);
        end
      end
      ir[7:5] == PFX_ALU: begin
        reg_en[REN_R] = 1'b1;
        x_sel = ir[4];
        y_sel = ir[3];
      end
      ir[7:4] == PFX_JMP: begin
        is_jump = 1'b1;
      end
      ir == INSN_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/sequence controller: pc, ir, run/halt FSM,
// two-word jump resolution for the 4-bit unit.
module program_sequencer
  import nano_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] pm_addr,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  input  logic            resume,
  output logic            sync_reset,
  output logic [3:0]      nibble_ir,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            halted
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [7:0]      ir, ir_n;

  logic [8:0] dec_en;
  logic       is_jump;
  logic       is_halt;
  logic [3:0] jump_cond;
  logic       take;
  logic       run;

  nano_decoder u_dec (
    .ir         (ir),
    .reg_en     (dec_en),
    .source_sel (source_sel),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .is_jump    (is_jump),
    .jump_cond  (jump_cond),
    .is_halt    (is_halt)
  );

  assign pm_addr   = pc;
  assign nibble_ir = ir[3:0];
  assign reg_en    = run ? dec_en : '0;

  always_comb begin
    take = 1'b0;
    unique case (jump_cond)
      JC_JMP:  take = 1'b1;
      JC_JZ:   take = r_eq_0;
      JC_JNZ:  take = !r_eq_0;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RST;
      pc    <= RESET_VEC;
      ir    <= INSN_NOP;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    sync_reset = 1'b0;
    halted     = 1'b0;
    run        = 1'b0;
    unique case (state)
      ST_RST: begin
        sync_reset = 1'b1;
        state_n    = ST_RUN;
      end
      ST_RUN: begin
        run = 1'b1;
        if (is_halt) begin
          state_n = ST_HALT;
          ir_n    = INSN_NOP;
        end else if (is_jump) begin
          // pm_data holds the target word here
          ir_n = INSN_NOP;
          if (take)
            pc_n = PC_W'(pm_data);
          else
            pc_n = pc + PC_W'(1);
        end else begin
          ir_n = pm_data;
          pc_n = pc + PC_W'(1);
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume)
          state_n = ST_RUN;
      end
      default: state_n = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: decode table,
// jump table, halt/resume, wrap-around and reset corners.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       r_eq_0 = 1'b0;
  logic       resume = 1'b0;
  logic       sync_reset;
  logic [3:0] nibble_ir;
  logic       i_sel, x_sel, y_sel;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       halted;

  logic [7:0] pm [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign pm_data = pm[pm_addr];

  program_sequencer #(
    .PC_W      (8),
    .RESET_VEC (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_addr    (pm_addr),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
    .resume     (resume),
    .sync_reset (sync_reset),
    .nibble_ir  (nibble_ir),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .halted     (halted)
  );

  typedef struct {
    logic [7:0] word;
    logic [8:0] en;
    logic [3:0] src;
    logic       is;
    logic       xs;
    logic       ys;
  } vec_t;

  typedef struct {
    logic [7:0] word;
    logic       z;
    logic [7:0] nxt;
  } jv_t;

  vec_t vecs [15];
  jv_t  jvs  [6];

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int a = 0; a < 256; a++)
      pm[a] = 8'hF0;
  endtask

  // Ends one cycle into RUN with pc at the reset vector.
  task automatic do_reset();
    resume  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    logic [19:0] act;
    logic [19:0] exp;

    vecs[0]  = '{8'h05, 9'h001, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hC2, 9'h010, 4'd10, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h8F, 9'h042, 4'd7,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'hB8, 9'h0C0, 4'd0,  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'hB7, 9'h040, 4'd7,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hA4, 9'h100, 4'd9,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hBF, 9'h0C0, 4'd9,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'hDB, 9'h010, 4'd10, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{8'hF5, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h7A, 9'h080, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h4C, 9'h100, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h93, 9'h004, 4'd3,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h8D, 9'h002, 4'd5,  1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'hB5, 9'h040, 4'd5,  1'b0, 1'b0, 1'b0};
    vecs[14] = '{8'hE9, 9'h000, 4'd10, 1'b0, 1'b0, 1'b0};

    jvs[0] = '{8'hE1, 1'b1, 8'h20};
    jvs[1] = '{8'hE1, 1'b0, 8'h06};
    jvs[2] = '{8'hE2, 1'b0, 8'h20};
    jvs[3] = '{8'hE2, 1'b1, 8'h06};
    jvs[4] = '{8'hE0, 1'b0, 8'h20};
    jvs[5] = '{8'hE7, 1'b1, 8'h06};

    // Reset state, then straight-line decode table
    load_nops();
    for (int i = 0; i < 14; i++)
      pm[i] = vecs[i].word;
    @(posedge clk);
    #1;
    check("rst_addr", 32'(pm_addr), 32'h00);
    check("rst_en", 32'(reg_en), 32'h0);
    check("rst_sync", 32'(sync_reset), 32'h1);
    check("rst_src", 32'(source_sel), 32'd10);
    check("rst_sels", 32'({i_sel, x_sel, y_sel}), 32'h0);
    check("rst_nib", 32'(nibble_ir), 32'h0);
    check("rst_halt", 32'(halted), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_cycle_sync", 32'(sync_reset), 32'h1);
    tick();
    check("run_sync", 32'(sync_reset), 32'h0);
    check("run_addr0", 32'(pm_addr), 32'h00);
    check("run_en0", 32'(reg_en), 32'h0);
    for (int i = 0; i < 14; i++) begin
      tick();
      act = {reg_en, source_sel, i_sel,
             x_sel, y_sel, nibble_ir};
      exp = {vecs[i].en, vecs[i].src, vecs[i].is,
             vecs[i].xs, vecs[i].ys, vecs[i].word[3:0]};
      check($sformatf("vec%0d_ctl", i),
            32'(act), 32'(exp));
      check($sformatf("vec%0d_addr", i),
            32'(pm_addr), i + 1);
    end

    // Jump table at address 4, target word 20
    for (int j = 0; j < 6; j++) begin
      load_nops();
      pm[4]     = jvs[j].word;
      pm[5]     = 8'h20;
      pm[6]     = 8'h05;
      pm[8'h20] = 8'h05;
      r_eq_0    = jvs[j].z;
      do_reset();
      repeat (4) tick();
      check($sformatf("jmp%0d_a4", j), 32'(pm_addr), 32'h04);
      tick();
      check($sformatf("jmp%0d_a5", j), 32'(pm_addr), 32'h05);
      check($sformatf("jmp%0d_en1", j), 32'(reg_en), 32'h0);
      tick();
      check($sformatf("jmp%0d_tgt", j),
            32'(pm_addr), 32'(jvs[j].nxt));
      check($sformatf("jmp%0d_en2", j), 32'(reg_en), 32'h0);
      tick();
      check($sformatf("jmp%0d_nxt", j),
            32'(pm_addr), 32'(jvs[j].nxt) + 1);
      check($sformatf("jmp%0d_exec", j), 32'(reg_en), 32'h001);
    end

    // Reset asserted while the jump is in ir
    load_nops();
    pm[4] = 8'hE0;
    pm[5] = 8'h20;
    do_reset();
    repeat (5) tick();
    check("mid_jmp_addr", 32'(pm_addr), 32'h05);
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(pm_addr), 32'h00);
    check("mid_rst_sync", 32'(sync_reset), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("mid_rst_run", 32'(pm_addr), 32'h00);
    tick();
    check("mid_rst_step", 32'(pm_addr), 32'h01);

    // HALT at FF: pc wraps to 00 and holds
    load_nops();
    pm[0]     = 8'hE0;
    pm[1]     = 8'hFF;
    pm[8'hFF] = 8'hFF;
    do_reset();
    tick();
    tick();
    check("halt_fetch", 32'(pm_addr), 32'hFF);
    tick();
    check("halt_dec_addr", 32'(pm_addr), 32'h00);
    check("halt_dec_flag", 32'(halted), 32'h0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("halt_ign_resume", 32'(halted), 32'h1);
    check("halt_addr", 32'(pm_addr), 32'h00);
    check("halt_en", 32'(reg_en), 32'h0);
    repeat (3) tick();
    check("halt_hold", 32'(halted), 32'h1);
    check("halt_hold_addr", 32'(pm_addr), 32'h00);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_flag", 32'(halted), 32'h0);
    check("resume_addr", 32'(pm_addr), 32'h00);
    tick();
    check("resume_step", 32'(pm_addr), 32'h01);

    // Reset while halted
    load_nops();
    pm[0] = 8'hFF;
    do_reset();
    tick();
    tick();
    check("halt2_flag", 32'(halted), 32'h1);
    reset_n = 1'b0;
    #1;
    check("halt_rst_flag", 32'(halted), 32'h0);
    check("halt_rst_sync", 32'(sync_reset), 32'h1);
    check("halt_rst_addr", 32'(pm_addr), 32'h00);

    // Jump at FF takes target from 00
    load_nops();
    pm[0]     = 8'hE0;
    pm[1]     = 8'hFF;
    pm[8'hFF] = 8'hE0;
    pm[8'hE0] = 8'h05;
    do_reset();
    tick();
    tick();
    tick();
    check("wrapj_addr", 32'(pm_addr), 32'h00);
    check("wrapj_en", 32'(reg_en), 32'h0);
    tick();
    check("wrapj_tgt", 32'(pm_addr), 32'hE0);
    tick();
    check("wrapj_exec", 32'(reg_en), 32'h001);
    check("wrapj_next", 32'(pm_addr), 32'hE1);

    // Not-taken jump at FE continues at 00
    load_nops();
    pm[0]     = 8'hE0;
    pm[1]     = 8'hFE;
    pm[8'hFE] = 8'hE3;
    pm[8'hFF] = 8'h05;
    r_eq_0    = 1'b1;
    do_reset();
    tick();
    tick();
    check("wrapn_fe", 32'(pm_addr), 32'hFE);
    tick();
    check("wrapn_ff", 32'(pm_addr), 32'hFF);
    tick();
    check("wrapn_00", 32'(pm_addr), 32'h00);
    check("wrapn_en", 32'(reg_en), 32'h0);
    tick();
    check("wrapn_01", 32'(pm_addr), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
